// File: rtl/regfile_tagged.sv
// rtl/regfile_tagged.sv - architectural register file with per-register busy/owner tags
//
// Purpose: holds value, busy and owner tag for every architectural register.
//   Dispatch marks a register busy under a new owner tag. Retirement writes a
//   result and releases busy only if the retiring tag still owns the register.
//   Read ports register the post-update state, so same-cycle writes are visible.
//
// Ports (per-port buses packed flat, port i at [i*W +: W]):
//   clk, rst            clock, asynchronous active-high reset
//   rd_en/rd_addr       per-port read enable and register index
//   rd_value/rd_busy/
//   rd_owner            registered read results (hold when rd_en is low)
//   alloc_en/alloc_reg/
//   alloc_tag           dispatch allocation: set busy, record owner
//   ret_en/ret_reg/
//   ret_data/ret_tag    retirement write ports
module regfile_tagged #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16,
  parameter int TAG_W  = 4,
  parameter int NREAD  = 8,
  parameter int NRET   = 4,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREAD-1:0]         rd_en,
  input  logic [NREAD*ADDR_W-1:0]  rd_addr,
  output logic [NREAD*DATA_W-1:0]  rd_value,
  output logic [NREAD-1:0]         rd_busy,
  output logic [NREAD*TAG_W-1:0]   rd_owner,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_reg,
  input  logic [TAG_W-1:0]         alloc_tag,
  input  logic [NRET-1:0]          ret_en,
  input  logic [NRET*ADDR_W-1:0]   ret_reg,
  input  logic [NRET*DATA_W-1:0]   ret_data,
  input  logic [NRET*TAG_W-1:0]    ret_tag
);

  logic [NREGS-1:0][DATA_W-1:0] val_q, val_d;
  logic [NREGS-1:0]             busy_q, busy_d;
  logic [NREGS-1:0][TAG_W-1:0]  own_q, own_d;

  // Next architectural state. Retire ports are applied in ascending order so
  // the highest-index port's data wins a collision. Busy release compares
  // against the pre-edge owner (own_q), and allocation is applied last so it
  // overrides any release to the same register.
  always_comb begin
    val_d  = val_q;
    busy_d = busy_q;
    own_d  = own_q;
    for (int i = 0; i < NRET; i++) begin
      if (ret_en[i]) begin
        val_d[ret_reg[i*ADDR_W +: ADDR_W]] = ret_data[i*DATA_W +: DATA_W];
        if (own_q[ret_reg[i*ADDR_W +: ADDR_W]] == ret_tag[i*TAG_W +: TAG_W])
          busy_d[ret_reg[i*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (alloc_en) begin
      busy_d[alloc_reg] = 1'b1;
      own_d[alloc_reg]  = alloc_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q    <= '0;
      busy_q   <= '0;
      own_q    <= '0;
      rd_value <= '0;
      rd_busy  <= '0;
      rd_owner <= '0;
    end else begin
      val_q  <= val_d;
      busy_q <= busy_d;
      own_q  <= own_d;
      // Reads sample next-state so same-cycle retire/alloc write through.
      for (int p = 0; p < NREAD; p++) begin
        if (rd_en[p]) begin
          rd_value[p*DATA_W +: DATA_W] <= val_d[rd_addr[p*ADDR_W +: ADDR_W]];
          rd_busy[p]                   <= busy_d[rd_addr[p*ADDR_W +: ADDR_W]];
          rd_owner[p*TAG_W +: TAG_W]   <= own_d[rd_addr[p*ADDR_W +: ADDR_W]];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_tagged.sv
// tb/tb_regfile_tagged.sv - randomized and directed bench for regfile_tagged
module tb_regfile_tagged;

  // Instance A: default parameters. Instance B: sweep configuration.
  localparam int A_D = 16, A_N = 16, A_A = 4, A_R = 8, A_T = 4;
  localparam int B_D = 32, B_N = 32, B_A = 5, B_R = 2, B_T = 1;
  localparam int TW  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int phase = 0;
  int nregs, nread, nret;
  logic [31:0] dmask;

  // Abstract stimulus, shared by both instances.
  bit          r_en   [8];
  logic [4:0]  r_addr [8];
  bit          a_en;
  logic [4:0]  a_reg;
  logic [3:0]  a_tag;
  bit          t_en   [4];
  logic [4:0]  t_reg  [4];
  logic [31:0] t_data [4];
  logic [3:0]  t_tag  [4];

  // Reference model state and expected read outputs.
  logic [31:0] m_val  [32];
  bit          m_busy [32];
  logic [3:0]  m_own  [32];
  logic [31:0] e_val  [8];
  bit          e_busy [8];
  logic [3:0]  e_own  [8];

  logic [A_R-1:0]     a_rd_en;
  logic [A_R*A_A-1:0] a_rd_addr;
  logic [A_R*A_D-1:0] a_rd_value;
  logic [A_R-1:0]     a_rd_busy;
  logic [A_R*TW-1:0]  a_rd_owner;
  logic               a_alloc_en;
  logic [A_A-1:0]     a_alloc_reg;
  logic [TW-1:0]      a_alloc_tag;
  logic [A_T-1:0]     a_ret_en;
  logic [A_T*A_A-1:0] a_ret_reg;
  logic [A_T*A_D-1:0] a_ret_data;
  logic [A_T*TW-1:0]  a_ret_tag;

  logic [B_R-1:0]     b_rd_en;
  logic [B_R*B_A-1:0] b_rd_addr;
  logic [B_R*B_D-1:0] b_rd_value;
  logic [B_R-1:0]     b_rd_busy;
  logic [B_R*TW-1:0]  b_rd_owner;
  logic               b_alloc_en;
  logic [B_A-1:0]     b_alloc_reg;
  logic [TW-1:0]      b_alloc_tag;
  logic [B_T-1:0]     b_ret_en;
  logic [B_T*B_A-1:0] b_ret_reg;
  logic [B_T*B_D-1:0] b_ret_data;
  logic [B_T*TW-1:0]  b_ret_tag;

  regfile_tagged #(.DATA_W(A_D), .NREGS(A_N), .TAG_W(TW), .NREAD(A_R), .NRET(A_T)) dut_a (
    .clk(clk), .rst(rst),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_value(a_rd_value),
    .rd_busy(a_rd_busy), .rd_owner(a_rd_owner),
    .alloc_en(a_alloc_en), .alloc_reg(a_alloc_reg), .alloc_tag(a_alloc_tag),
    .ret_en(a_ret_en), .ret_reg(a_ret_reg), .ret_data(a_ret_data), .ret_tag(a_ret_tag)
  );

  regfile_tagged #(.DATA_W(B_D), .NREGS(B_N), .TAG_W(TW), .NREAD(B_R), .NRET(B_T)) dut_b (
    .clk(clk), .rst(rst),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_value(b_rd_value),
    .rd_busy(b_rd_busy), .rd_owner(b_rd_owner),
    .alloc_en(b_alloc_en), .alloc_reg(b_alloc_reg), .alloc_tag(b_alloc_tag),
    .ret_en(b_ret_en), .ret_reg(b_ret_reg), .ret_data(b_ret_data), .ret_tag(b_ret_tag)
  );

  // Route the abstract stimulus to whichever instance is under test.
  always_comb begin
    for (int i = 0; i < A_R; i++) begin
      a_rd_en[i]             = (phase == 0) && r_en[i];
      a_rd_addr[i*A_A +: A_A] = r_addr[i][A_A-1:0];
    end
    a_alloc_en  = (phase == 0) && a_en;
    a_alloc_reg = a_reg[A_A-1:0];
    a_alloc_tag = a_tag;
    for (int i = 0; i < A_T; i++) begin
      a_ret_en[i]              = (phase == 0) && t_en[i];
      a_ret_reg[i*A_A +: A_A]  = t_reg[i][A_A-1:0];
      a_ret_data[i*A_D +: A_D] = t_data[i][A_D-1:0];
      a_ret_tag[i*TW +: TW]    = t_tag[i];
    end
  end

  always_comb begin
    for (int i = 0; i < B_R; i++) begin
      b_rd_en[i]              = (phase == 1) && r_en[i];
      b_rd_addr[i*B_A +: B_A] = r_addr[i];
    end
    b_alloc_en  = (phase == 1) && a_en;
    b_alloc_reg = a_reg;
    b_alloc_tag = a_tag;
    for (int i = 0; i < B_T; i++) begin
      b_ret_en[i]              = (phase == 1) && t_en[i];
      b_ret_reg[i*B_A +: B_A]  = t_reg[i];
      b_ret_data[i*B_D +: B_D] = t_data[i];
      b_ret_tag[i*TW +: TW]    = t_tag[i];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 8; i++) begin r_en[i] = 0; r_addr[i] = '0; end
    a_en = 0; a_reg = '0; a_tag = '0;
    for (int i = 0; i < 4; i++) begin
      t_en[i] = 0; t_reg[i] = '0; t_data[i] = '0; t_tag[i] = '0;
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin m_val[r] = '0; m_busy[r] = 0; m_own[r] = '0; end
    for (int p = 0; p < 8; p++) begin e_val[p] = '0; e_busy[p] = 0; e_own[p] = '0; end
  endtask

  // One architectural cycle as described by the rules: values from every
  // retirement (later port overwrites earlier), busy released if any retiring
  // tag equals the owner before the cycle, then allocation takes the register.
  task automatic model_step();
    logic [3:0] prev_own [32];
    bit         release_r [32];
    for (int r = 0; r < 32; r++) begin prev_own[r] = m_own[r]; release_r[r] = 0; end
    for (int i = 0; i < nret; i++)
      if (t_en[i]) begin
        m_val[t_reg[i]] = t_data[i] & dmask;
        if (prev_own[t_reg[i]] == t_tag[i]) release_r[t_reg[i]] = 1;
      end
    for (int r = 0; r < 32; r++) if (release_r[r]) m_busy[r] = 0;
    if (a_en) begin m_busy[a_reg] = 1; m_own[a_reg] = a_tag; end
    for (int p = 0; p < nread; p++)
      if (r_en[p]) begin
        e_val[p] = m_val[r_addr[p]]; e_busy[p] = m_busy[r_addr[p]]; e_own[p] = m_own[r_addr[p]];
      end
  endtask

  task automatic check_ports();
    for (int p = 0; p < nread; p++) begin
      if (phase == 0) begin
        check($sformatf("a_p%0d_value", p), 64'(a_rd_value[p*A_D +: A_D]), 64'(e_val[p]));
        check($sformatf("a_p%0d_busy", p), 64'(a_rd_busy[p]), 64'(e_busy[p]));
        check($sformatf("a_p%0d_owner", p), 64'(a_rd_owner[p*TW +: TW]), 64'(e_own[p]));
      end else begin
        check($sformatf("b_p%0d_value", p), 64'(b_rd_value[p*B_D +: B_D]), 64'(e_val[p]));
        check($sformatf("b_p%0d_busy", p), 64'(b_rd_busy[p]), 64'(e_busy[p]));
        check($sformatf("b_p%0d_owner", p), 64'(b_rd_owner[p*TW +: TW]), 64'(e_own[p]));
      end
    end
  endtask

  // Inputs are driven 1 time unit after a rising edge; outputs are checked
  // 1 time unit after the edge that consumes them.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_ports();
    clear_inputs();
  endtask

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, nregs - 1));
    return 5'($urandom_range(0, 7));
  endfunction

  task automatic rand_inputs();
    clear_inputs();
    for (int p = 0; p < nread; p++) begin r_en[p] = ($urandom_range(0, 1) == 1); r_addr[p] = rand_addr(); end
    a_en = ($urandom_range(0, 1) == 1); a_reg = rand_addr(); a_tag = 4'($urandom_range(0, 3));
    for (int i = 0; i < nret; i++) begin
      t_en[i] = ($urandom_range(0, 1) == 1); t_reg[i] = rand_addr();
      t_data[i] = $urandom; t_tag[i] = 4'($urandom_range(0, 3));
    end
  endtask

  task automatic select_a();
    phase = 0; nregs = A_N; nread = A_R; nret = A_T; dmask = 32'h0000_FFFF;
  endtask

  initial begin
    select_a();
    clear_inputs();
    model_reset();
    #3;
    check("reset_value", 64'(a_rd_value), 64'd0);
    check("reset_busy", 64'(a_rd_busy), 64'd0);
    check("reset_owner", 64'(a_rd_owner), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Allocate then retire with matching tag, read-through on port 2.
    a_en = 1; a_reg = 3; a_tag = 7; step();
    t_en[0] = 1; t_reg[0] = 3; t_data[0] = 32'hBEEF; t_tag[0] = 7;
    r_en[2] = 1; r_addr[2] = 3; step();
    check("match_value", 64'(a_rd_value[2*A_D +: A_D]), 64'hBEEF);
    check("match_busy", 64'(a_rd_busy[2]), 64'd0);
    check("match_owner", 64'(a_rd_owner[2*TW +: TW]), 64'd7);

    // Stale retire: younger owner keeps busy.
    a_en = 1; a_reg = 3; a_tag = 7; step();
    a_en = 1; a_reg = 3; a_tag = 9; step();
    t_en[1] = 1; t_reg[1] = 3; t_data[1] = 32'h1234; t_tag[1] = 7;
    r_en[0] = 1; r_addr[0] = 3; step();
    check("stale_value", 64'(a_rd_value[0 +: A_D]), 64'h1234);
    check("stale_busy", 64'(a_rd_busy[0]), 64'd1);
    check("stale_owner", 64'(a_rd_owner[0 +: TW]), 64'd9);

    // Collision: ports 0 and 3 on r1, only port 0 matches owner 6.
    a_en = 1; a_reg = 1; a_tag = 6; step();
    t_en[0] = 1; t_reg[0] = 1; t_data[0] = 32'h0011; t_tag[0] = 6;
    t_en[3] = 1; t_reg[3] = 1; t_data[3] = 32'h0033; t_tag[3] = 2;
    r_en[1] = 1; r_addr[1] = 1; step();
    check("collide_value", 64'(a_rd_value[1*A_D +: A_D]), 64'h0033);
    check("collide_busy", 64'(a_rd_busy[1]), 64'd0);

    // Allocation and matching retirement in the same cycle.
    a_en = 1; a_reg = 4; a_tag = 2; step();
    t_en[2] = 1; t_reg[2] = 4; t_data[2] = 32'hAAAA; t_tag[2] = 2;
    a_en = 1; a_reg = 4; a_tag = 5;
    r_en[5] = 1; r_addr[5] = 4; step();
    check("allocret_value", 64'(a_rd_value[5*A_D +: A_D]), 64'hAAAA);
    check("allocret_busy", 64'(a_rd_busy[5]), 64'd1);
    check("allocret_owner", 64'(a_rd_owner[5*TW +: TW]), 64'd5);

    // Mid-cycle asynchronous reset after writes to r5.
    a_en = 1; a_reg = 5; a_tag = 3; step();
    t_en[0] = 1; t_reg[0] = 5; t_data[0] = 32'h5555; t_tag[0] = 1;
    for (int p = 0; p < 8; p++) begin r_en[p] = 1; r_addr[p] = 5; end
    step();
    #3 rst = 1'b1;
    #1;
    check("midreset_value", 64'(a_rd_value), 64'd0);
    check("midreset_busy", 64'(a_rd_busy), 64'd0);
    check("midreset_owner", 64'(a_rd_owner), 64'd0);
    model_reset();
    #1 rst = 1'b0;
    r_en[0] = 1; r_addr[0] = 5; step();
    check("postreset_r5_value", 64'(a_rd_value[0 +: A_D]), 64'd0);
    check("postreset_r5_busy", 64'(a_rd_busy[0]), 64'd0);
    check("postreset_r5_owner", 64'(a_rd_owner[0 +: TW]), 64'd0);

    // Random traffic on the default configuration.
    for (int n = 0; n < 400; n++) begin rand_inputs(); step(); end

    // Parameter sweep instance: fresh reset, then random traffic.
    phase = 1; nregs = B_N; nread = B_R; nret = B_T; dmask = 32'hFFFF_FFFF;
    clear_inputs();
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    for (int n = 0; n < 400; n++) begin rand_inputs(); step(); end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_tagged.md
# regfile_tagged

Parametrised architectural register file with per-register busy/owner tags for the out-of-order core. It sits between dispatch (which allocates destination tags), the instruction buffer (which reads operands and their readiness), and retirement (which writes results back and releases tags). Compared with the previous register file, it adds:
- reset;
- an allocation port that marks registers busy;
- tag-checked busy release applied to the register state itself;
- same-cycle write-through on reads;
- arbitrary port counts and widths.

## Interface
- DATA_W, 16, register value width
- NREGS, 16, number of architectural registers (power of two, ≥2)
- TAG_W, 4, owner tag width
- NREAD, 8, number of read ports
- NRET, 4, number of retirement write ports
- ADDR_W, log2(NREGS), derived register index width (localparam)

Ports. Per-port buses are packed flat; port i occupies slice [i*W +: W].
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- rd_en  in  NREAD  per-port read enable
- rd_addr  in  NREAD*ADDR_W  read register index
- rd_value  out  NREAD*DATA_W  registered read value
- rd_busy  out  NREAD  registered busy bit
- rd_owner  out  NREAD*TAG_W  registered owner tag
- alloc_en  in  1  dispatch allocates destination register
- alloc_reg  in  ADDR_W  register being allocated
- alloc_tag  in  TAG_W  tag of new owner
- ret_en  in  NRET  per-port retirement write enable
- ret_reg  in  NRET*ADDR_W  target register
- ret_data  in  NRET*DATA_W  result value
- ret_tag  in  NRET*TAG_W  tag of retiring instruction

## Operation
- **State per register:** value[DATA_W], busy, owner[TAG_W].
- **Reset:** all values, busy and owner bits are 0; all rd_* outputs are 0. Reset is asynchronous and takes effect mid-cycle regardless of any enables.
- **Retirement port i with ret_en[i]:**
  - value[ret_reg] is updated to ret_data unconditionally.
  - busy[ret_reg] is cleared only if owner[ret_reg] (pre-edge state) == ret_tag[i].
  - A tag mismatch means a younger instruction owns the register: the value is still written, busy stays set.
- **Multiple retire ports targeting the same register in one cycle:**
  - The highest-index port's data wins.
  - busy clears if any of those ports matches the owner.
- **Allocation with alloc_en:** busy[alloc_reg] is set to 1 and owner[alloc_reg] is set to alloc_tag. The value is unchanged.
- **Allocation and retirement to the same register in the same cycle:**
  - Allocation wins for busy and owner.
  - The retirement value is still written.
- **Read port i with rd_en[i]:**
  - The outputs load the post-update (next-state) value, busy and owner of rd_addr[i].
  - This means same-cycle retirements and allocations are visible (write-through).
- **Read port with rd_en[i]=0:** outputs hold their previous contents.
- **Read ports are independent.** Any number of ports may read the same register.
- **No hardwired zero register.** Out-of-range indices cannot occur (NREGS is a power of two).

## Timing
- Read latency is 1 cycle: address at edge N gives data valid after edge N until the next enabled read.
- Write latency: architectural state is updated at the edge where ret_en/alloc_en are sampled. A read issued in that same cycle observes the new state.
- There is no handshake and no stall. Every enabled request completes in one cycle.
- Tag comparison for busy release always uses pre-edge owner, never the same-cycle alloc_tag.

## Test plan
- **Reset:** assert rst asynchronously mid-cycle after writes → all rd_* outputs 0 immediately; a read of r5 after release returns value 0, busy 0, owner 0.
- **Allocate, retire with matching tag:** alloc r3 tag 7; next cycle retire r3 data 0xBEEF tag 7 while reading r3 on port 2 → port 2 shows 0xBEEF, busy 0, owner 7.
- **Stale retire:** alloc r3 tag 7, then alloc r3 tag 9, then retire r3 tag 7 data 0x1234 → read shows 0x1234, busy 1, owner 9.
- **Collision:** retire ports 0 and 3 both target r1 (data 0x0011 / 0x0033, port 0 tag matches owner) → value 0x0033, busy 0.
- **Alloc vs retire same cycle:** r4 owned by tag 2; same cycle retire r4 tag 2 data 0xAAAA and alloc r4 tag 5 → value 0xAAAA, busy 1, owner 5, visible on a same-cycle read.
- **Parameter sweep:** NREGS=32, NREAD=2, NRET=1, DATA_W=32; random alloc/retire/read traffic checked against a reference model; read-enable-low ports verified to hold their outputs.
